arm_decode_fsm: RTL and testbench

Multi-cycle, registered successor to the combinational ARM decoder. It accepts one instruction per valid/ready handshake and sequences it through decode, an optional register-shift read, execute and memory states. It drives the register file, shifter muxes, ALU and a simple memory request port. It sits between fetch and the datapath in arm_core.

---
 rtl/arm_decode_fsm.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_arm_decode_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_decode_fsm.sv
// arm_decode_fsm: multi-cycle registered ARM instruction sequencer.
// Accepts one instruction per valid/ready handshake and steps it through
// DECODE, optional RSREAD, EXEC and MEM, driving register file, shifter,
// ALU and memory request controls. All outputs are registered.
// Optional build macro: ARM_DECODE_PERF_EN adds perf_retired/perf_skipped.
module arm_decode_fsm #(
  parameter int DATA_WIDTH  = 32,
  parameter int LINK_REG    = 14,
  parameter int PC_INC      = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [31:0]           inst,
  input  logic                  cond_pass,
  input  logic [DATA_WIDTH-1:0] pc_out,
  input  logic [DATA_WIDTH-1:0] rm_out,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [3:0]            read_rn,
  output logic [3:0]            read_rm,
  output logic [3:0]            read_rs,
  output logic [3:0]            write_rd,
  output logic                  rd_we,
  output logic                  pc_we,
  output logic                  cpsr_we,
  output logic [DATA_WIDTH-1:0] rd_in,
  output logic [DATA_WIDTH-1:0] pc_in,
  output logic [1:0]            shiftee_sel,
  output logic [1:0]            shifter_sel,
  output logic [3:0]            barrel_sel,
  output logic [3:0]            alu_sel,
  output logic [DATA_WIDTH-1:0] immed_32_shiftee_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_abort,
  output logic                  halted
`ifdef ARM_DECODE_PERF_EN
  ,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_skipped
`endif
);

  // Shared mux/op encodings used by the datapath.
  localparam logic [1:0] SHIFTEE_RM    = 2'd0;
  localparam logic [1:0] SHIFTEE_IMM8  = 2'd1;
  localparam logic [1:0] SHIFTEE_IMM32 = 2'd2;
  localparam logic [1:0] SHIFTER_IMM5  = 2'd0;
  localparam logic [1:0] SHIFTER_RS    = 2'd1;
  localparam logic [1:0] SHIFTER_ROT   = 2'd2;
  localparam logic [1:0] SHIFTER_ZERO  = 2'd3;
  localparam logic [3:0] BARREL_LSL    = 4'd0;
  localparam logic [3:0] BARREL_ROR    = 4'd3;
  localparam logic [3:0] ALU_SUB       = 4'd2;
  localparam logic [3:0] ALU_ADD       = 4'd4;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RSREAD, S_EXEC, S_MEM, S_HALT
  } state_e;

  typedef struct packed {
    logic                  inst_ready;
    logic [3:0]            read_rn;
    logic [3:0]            read_rm;
    logic [3:0]            read_rs;
    logic [3:0]            write_rd;
    logic                  rd_we;
    logic                  pc_we;
    logic                  cpsr_we;
    logic [DATA_WIDTH-1:0] rd_in;
    logic [DATA_WIDTH-1:0] pc_in;
    logic [1:0]            shiftee_sel;
    logic [1:0]            shifter_sel;
    logic [3:0]            barrel_sel;
    logic [3:0]            alu_sel;
    logic [DATA_WIDTH-1:0] immed;
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_abort;
    logic                  halted;
  } out_t;

  state_e            state_q, state_d;
  logic [27:0]       inst_q, inst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  out_t              out_q, out_d;

  // Condition bits are resolved upstream via cond_pass, so only [27:0] is kept.
  logic [1:0]            cls;
  logic                  is_rs, is_ext, is_test, accept, timeout;
  logic [DATA_WIDTH-1:0] br_imm, mem_imm;

  assign cls     = inst_q[27:26];
  assign is_rs   = (cls == 2'b00) && !inst_q[25] && inst_q[4] && !inst_q[7];
  assign is_ext  = (cls == 2'b00) && !inst_q[25] && inst_q[4] && inst_q[7];
  assign is_test = (inst_q[24:23] == 2'b10);
  assign accept  = (state_q == S_IDLE) && inst_valid && out_q.inst_ready;
  assign timeout = (cnt_q == CNT_LAST);
  assign br_imm  = ({{(DATA_WIDTH-24){inst_q[23]}}, inst_q[23:0]} << 2) + DATA_WIDTH'(4);
  assign mem_imm = {{(DATA_WIDTH-12){1'b0}}, inst_q[11:0]};

  // State, captured instruction, wait counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      inst_q  <= 28'd0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Next-state sequencing, instruction capture and MEM wait counting.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DECODE;
          inst_d  = inst[27:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (!cond_pass) begin
          state_d = S_IDLE;
        end else begin
          case (cls)
            2'b00:   state_d = is_rs ? S_RSREAD : (is_ext ? S_IDLE : S_EXEC);
            2'b10:   state_d = S_EXEC;
            2'b01:   state_d = S_MEM;
            default: state_d = (inst_q[25:24] == 2'b11) ? S_HALT : S_IDLE;
          endcase
        end
      end
      S_RSREAD: state_d = S_EXEC;
      S_EXEC:   state_d = S_IDLE;
      S_MEM: begin
        if (mem_ack || timeout) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle: controls, write pulses, memory port.
  always_comb begin
    out_d            = '0;
    out_d.inst_ready = (state_q == S_IDLE) && !accept;
    out_d.halted     = (state_q == S_HALT);
    if (state_q inside {S_DECODE, S_RSREAD, S_EXEC, S_MEM}) begin
      case (cls)
        2'b00: begin
          out_d.read_rn = inst_q[19:16];
          out_d.read_rm = inst_q[3:0];
          out_d.read_rs = inst_q[11:8];
          out_d.alu_sel = inst_q[24:21];
          if (inst_q[25]) begin
            out_d.shiftee_sel = SHIFTEE_IMM8;
            out_d.shifter_sel = SHIFTER_ROT;
            out_d.barrel_sel  = BARREL_ROR;
          end else if (inst_q[4]) begin
            out_d.shiftee_sel = SHIFTEE_RM;
            out_d.shifter_sel = SHIFTER_RS;
            out_d.barrel_sel  = {2'b01, inst_q[6:5]};
          end else begin
            out_d.shiftee_sel = SHIFTEE_RM;
            out_d.shifter_sel = SHIFTER_IMM5;
            out_d.barrel_sel  = {2'b00, inst_q[6:5]};
          end
        end
        2'b10: begin
          out_d.read_rn     = 4'd15;
          out_d.alu_sel     = ALU_ADD;
          out_d.shiftee_sel = SHIFTEE_IMM32;
          out_d.shifter_sel = SHIFTER_ZERO;
          out_d.barrel_sel  = BARREL_LSL;
          out_d.immed       = br_imm;
        end
        2'b01: begin
          out_d.read_rn     = inst_q[19:16];
          out_d.read_rm     = inst_q[15:12];
          out_d.alu_sel     = inst_q[23] ? ALU_ADD : ALU_SUB;
          out_d.shiftee_sel = SHIFTEE_IMM32;
          out_d.shifter_sel = SHIFTER_ZERO;
          out_d.barrel_sel  = BARREL_LSL;
          out_d.immed       = mem_imm;
        end
        default: out_d.immed = '0;
      endcase
    end else begin
      out_d.immed = '0;
    end
    case (state_q)
      S_EXEC: begin
        if (cls == 2'b10) begin
          out_d.pc_we = 1'b1;
          out_d.pc_in = alu_out;
          if (inst_q[24]) begin
            out_d.rd_we    = 1'b1;
            out_d.write_rd = 4'(LINK_REG);
            out_d.rd_in    = pc_out + DATA_WIDTH'(PC_INC);
          end else begin
            out_d.rd_we = 1'b0;
          end
        end else begin
          out_d.write_rd = inst_q[15:12];
          out_d.rd_in    = alu_out;
          out_d.rd_we    = !is_test;
          out_d.cpsr_we  = is_test || inst_q[20];
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          out_d.rd_we    = inst_q[20];
          out_d.rd_in    = mem_rdata;
          out_d.write_rd = inst_q[15:12];
        end else if (timeout) begin
          out_d.mem_abort = 1'b1;
        end else begin
          out_d.mem_req   = 1'b1;
          out_d.mem_we    = !inst_q[20];
          out_d.mem_addr  = alu_out;
          out_d.mem_wdata = rm_out;
        end
      end
      default: out_d.rd_we = 1'b0;
    endcase
  end

  assign inst_ready          = out_q.inst_ready;
  assign read_rn             = out_q.read_rn;
  assign read_rm             = out_q.read_rm;
  assign read_rs             = out_q.read_rs;
  assign write_rd            = out_q.write_rd;
  assign rd_we               = out_q.rd_we;
  assign pc_we               = out_q.pc_we;
  assign cpsr_we             = out_q.cpsr_we;
  assign rd_in               = out_q.rd_in;
  assign pc_in               = out_q.pc_in;
  assign shiftee_sel         = out_q.shiftee_sel;
  assign shifter_sel         = out_q.shifter_sel;
  assign barrel_sel          = out_q.barrel_sel;
  assign alu_sel             = out_q.alu_sel;
  assign immed_32_shiftee_in = out_q.immed;
  assign mem_req             = out_q.mem_req;
  assign mem_we              = out_q.mem_we;
  assign mem_addr            = out_q.mem_addr;
  assign mem_wdata           = out_q.mem_wdata;
  assign mem_abort           = out_q.mem_abort;
  assign halted              = out_q.halted;

`ifdef ARM_DECODE_PERF_EN
  // Retired and condition-skipped instruction counters (wrap naturally).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_retired <= 32'd0;
      perf_skipped <= 32'd0;
    end else begin
      if ((state_q == S_EXEC) || ((state_q == S_MEM) && mem_ack)) begin
        perf_retired <= perf_retired + 32'd1;
      end else begin
        perf_retired <= perf_retired;
      end
      if ((state_q == S_DECODE) && !cond_pass) begin
        perf_skipped <= perf_skipped + 32'd1;
      end else begin
        perf_skipped <= perf_skipped;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arm_decode_fsm.sv
// Self-checking bench for arm_decode_fsm: directed test-plan steps followed by
// randomized instructions, each checked against a field-level reference model.
module tb_arm_decode_fsm;

  localparam logic [3:0] ALU_ADD = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid, inst_ready, cond_pass, mem_ack;
  logic [31:0] inst, pc_out, rm_out, alu_out, mem_rdata;
  logic [3:0]  read_rn, read_rm, read_rs, write_rd;
  logic        rd_we, pc_we, cpsr_we;
  logic [31:0] rd_in, pc_in, immed_32_shiftee_in, mem_addr, mem_wdata;
  logic [1:0]  shiftee_sel, shifter_sel;
  logic [3:0]  barrel_sel, alu_sel;
  logic        mem_req, mem_we, mem_abort, halted;
`ifdef ARM_DECODE_PERF_EN
  logic [31:0] perf_retired, perf_skipped;
  int          exp_ret = 0;
  int          exp_skip = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arm_decode_fsm dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .cond_pass(cond_pass), .pc_out(pc_out), .rm_out(rm_out),
    .alu_out(alu_out), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .read_rn(read_rn), .read_rm(read_rm), .read_rs(read_rs), .write_rd(write_rd),
    .rd_we(rd_we), .pc_we(pc_we), .cpsr_we(cpsr_we), .rd_in(rd_in), .pc_in(pc_in),
    .shiftee_sel(shiftee_sel), .shifter_sel(shifter_sel), .barrel_sel(barrel_sel),
    .alu_sel(alu_sel), .immed_32_shiftee_in(immed_32_shiftee_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_abort(mem_abort), .halted(halted)
`ifdef ARM_DECODE_PERF_EN
    , .perf_retired(perf_retired), .perf_skipped(perf_skipped)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 40 && inst_ready !== 1'b1; t++) @(negedge clk);
    chk("accept_ready", {31'd0, inst_ready}, 32'd1);
  endtask

  // One instruction: model the expected outcome, hand it over, check each cycle.
  task automatic run_inst(input logic [31:0] w, input logic cp, input logic [31:0] av,
                          input logic [31:0] pv, input logic [31:0] rv,
                          input logic [31:0] md, input int d);
    int          we_cyc, rdy_cyc, off;
    logic        e_rd_we, e_pc_we, e_cpsr, e_abort;
    logic [3:0]  e_wrd;
    logic [31:0] e_rdin, e_pcin, e_imm;
    bit          is_dp, is_rs, is_br, is_mem;
    we_cyc = -1; rdy_cyc = 2;
    e_rd_we = 1'b0; e_pc_we = 1'b0; e_cpsr = 1'b0; e_abort = 1'b0;
    e_wrd = 4'd0; e_rdin = 32'd0; e_pcin = 32'd0; e_imm = 32'd0;
    is_dp = 0; is_rs = 0; is_br = 0; is_mem = 0;
    if (cp) begin
      case (w[27:26])
        2'b00: if (!(w[25] == 1'b0 && w[4] == 1'b1 && w[7] == 1'b1)) begin
          is_dp = 1; is_rs = (w[25] == 1'b0 && w[4] == 1'b1);
          we_cyc = is_rs ? 3 : 2;
          e_wrd = w[15:12]; e_rdin = av;
          if (w[24:21] >= 4'd8 && w[24:21] <= 4'd11) begin
            e_rd_we = 1'b0; e_cpsr = 1'b1;
          end else begin
            e_rd_we = 1'b1; e_cpsr = w[20];
          end
        end
        2'b10: begin
          is_br = 1; we_cyc = 2; e_pc_we = 1'b1; e_pcin = av;
          e_rd_we = w[24]; e_wrd = 4'd14; e_rdin = pv + 32'd4;
          off = int'(w[23:0]);
          if (off >= 8388608) off -= 16777216;
          e_imm = 32'(off * 4 + 4);
        end
        2'b01: begin
          is_mem = 1;
          we_cyc = (d <= 14) ? 3 + d : 17;
          if (d <= 14) begin
            e_rd_we = w[20]; e_wrd = w[15:12]; e_rdin = md;
          end else begin
            e_abort = 1'b1;
          end
        end
        default: ;
      endcase
      if (we_cyc > 0) rdy_cyc = we_cyc + 1;
    end
`ifdef ARM_DECODE_PERF_EN
    if (!cp) exp_skip++;
    else if (is_dp || is_br || (is_mem && d <= 14)) exp_ret++;
`endif
    cond_pass = cp; alu_out = av; pc_out = pv; rm_out = rv; mem_rdata = md; mem_ack = 1'b0;
    wait_ready();
    inst_valid = 1'b1; inst = w;
    @(posedge clk); @(negedge clk);
    inst_valid = 1'b0; inst = $urandom;
    chk("ready_drop", {31'd0, inst_ready}, 32'd0);
    for (int k = 1; k <= rdy_cyc; k++) begin
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0;
      if (k == we_cyc) begin
        chk("rd_we", {31'd0, rd_we}, {31'd0, e_rd_we});
        if (e_rd_we) begin
          chk("write_rd", {28'd0, write_rd}, {28'd0, e_wrd});
          chk("rd_in", rd_in, e_rdin);
        end
        chk("pc_we", {31'd0, pc_we}, {31'd0, e_pc_we});
        if (e_pc_we) chk("pc_in", pc_in, e_pcin);
        chk("cpsr_we", {31'd0, cpsr_we}, {31'd0, e_cpsr});
        chk("mem_abort", {31'd0, mem_abort}, {31'd0, e_abort});
      end else begin
        chk("no_pulse", {28'd0, rd_we, pc_we, cpsr_we, mem_abort}, 32'd0);
      end
      chk("inst_ready", {31'd0, inst_ready}, (k == rdy_cyc) ? 32'd1 : 32'd0);
      if (k == 1 && is_dp) begin
        chk("dp_rn", {28'd0, read_rn}, {28'd0, w[19:16]});
        chk("dp_rm", {28'd0, read_rm}, {28'd0, w[3:0]});
        chk("dp_alu", {28'd0, alu_sel}, {28'd0, w[24:21]});
        if (is_rs) begin
          chk("rs_rs", {28'd0, read_rs}, {28'd0, w[11:8]});
          chk("rs_shifter", {30'd0, shifter_sel}, 32'd1);
          chk("rs_barrel", {28'd0, barrel_sel}, 32'd4 + {30'd0, w[6:5]});
        end
        if (w[25]) chk("imm_shiftee", {30'd0, shiftee_sel}, 32'd1);
      end
      if (k == 1 && is_br) begin
        chk("br_immed", immed_32_shiftee_in, e_imm);
        chk("br_alu", {28'd0, alu_sel}, {28'd0, ALU_ADD});
        chk("br_rn", {28'd0, read_rn}, 32'd15);
      end
      if (k == 1 && is_mem) begin
        chk("mem_immed", immed_32_shiftee_in, {20'd0, w[11:0]});
        chk("mem_alu", {28'd0, alu_sel}, {28'd0, w[23] ? ALU_ADD : ALU_SUB});
        chk("mem_rm", {28'd0, read_rm}, {28'd0, w[15:12]});
      end
      if (k == 2 && is_mem) begin
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, ~w[20]});
        chk("mem_addr", mem_addr, av);
        chk("mem_wdata", mem_wdata, rv);
      end
      if (is_mem && k == 2 + d && mem_req === 1'b1) mem_ack = 1'b1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; inst_valid = 1'b0; inst = 32'd0; cond_pass = 1'b0; mem_ack = 1'b0;
    pc_out = 32'd0; rm_out = 32'd0; alu_out = 32'd0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_pulses", {26'd0, rd_we, pc_we, cpsr_we, mem_req, mem_abort, halted}, 32'd0);
    chk("rst_data", rd_in | pc_in | mem_addr | immed_32_shiftee_in, 32'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", {31'd0, inst_ready}, 32'd1);

    // Directed steps from the test plan.
    run_inst(32'hE2821005, 1'b1, 32'h0000000A, 32'h0, 32'h0, 32'h0, 0);
    run_inst(32'hE2821005, 1'b0, 32'h0000000A, 32'h0, 32'h0, 32'h0, 0);
    run_inst(32'hE1A00211, 1'b1, 32'h00000040, 32'h0, 32'h0, 32'h0, 0);
    run_inst(32'hEB000002, 1'b1, 32'h0000010C, 32'h100, 32'h0, 32'h0, 0);
    run_inst(32'hE1530004, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0, 0);
    run_inst(32'hE5943008, 1'b1, 32'h0000100C, 32'h0, 32'h0, 32'hDEADBEEF, 3);
    run_inst(32'hE5943008, 1'b1, 32'h0000100C, 32'h0, 32'h0, 32'hDEADBEEF, 99);
    run_inst(32'hE5943008, 1'b1, 32'h0000100C, 32'h0, 32'h0, 32'hCAFEF00D, 14);
    run_inst(32'hE5043010, 1'b1, 32'h00000FF0, 32'h0, 32'h55AA55AA, 32'h0, 0);
    run_inst(32'hE0000291, 1'b1, 32'h00000001, 32'h0, 32'h0, 32'h0, 0);
    run_inst(32'hEA000000 | 32'h00FFFFFE, 1'b1, 32'h00000200, 32'h0, 32'h0, 32'h0, 0);

    // Randomized instructions (SWI space excluded; halting is checked last).
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[31:28] = 4'hE;
      if (w[27:24] == 4'hF) w[24] = 1'b0;
      run_inst(w, ($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom,
               int'($urandom_range(0, 16)));
    end

`ifdef ARM_DECODE_PERF_EN
    chk("perf_retired", perf_retired, 32'(exp_ret));
    chk("perf_skipped", perf_skipped, 32'(exp_skip));
`endif

    // Reset asserted while a load waits in MEM.
    cond_pass = 1'b1; alu_out = 32'h2000;
    wait_ready();
    inst_valid = 1'b1; inst = 32'hE5943008;
    @(posedge clk); @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("mreq_before_rst", {31'd0, mem_req}, 32'd1);
    #1 reset = 1'b1;
    #1 chk("mreq_async_drop", {31'd0, mem_req}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_mrst", {31'd0, inst_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("no_write_after_mrst", {29'd0, rd_we, mem_req, mem_abort}, 32'd0);

    // SWI: sticky halt until reset.
    wait_ready();
    inst_valid = 1'b1; inst = 32'hEF000000;
    @(posedge clk); @(negedge clk);
    inst_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); @(negedge clk);
      chk("halted_held", {30'd0, halted, inst_ready}, 32'd2);
    end
    #1 reset = 1'b1;
    #1 chk("halt_cleared", {30'd0, halted, inst_ready}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_halt_rst", {30'd0, halted, inst_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
